// File: rtl/fifo_frame_reader_pkg.sv
// fifo_frame_reader_pkg: FSM states and tag bit positions shared by the frame reader files.
package fifo_frame_reader_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_t;
    localparam int TAG_SOF = 0;
    localparam int TAG_EOL = 1;
    localparam int TAG_EOF = 2;
    localparam int TAG_W   = 3;
endpackage

// File: rtl/fifo_frame_reader_if.sv
// fifo_frame_reader_if: FIFO read port plus tagged output stream; master is the reader side.
interface fifo_frame_reader_if #(
    parameter int C_DATA_WIDTH       = 8,
    parameter int C_FIFO_DEPTH_WIDTH = 4
);
    logic                          fifo_rd_en;
    logic [C_DATA_WIDTH-1:0]       fifo_rd_data;
    logic                          fifo_rd_empty;
    logic [C_FIFO_DEPTH_WIDTH:0]   fifo_rd_cnt;
    logic                          m_valid;
    logic                          m_ready;
    logic [C_DATA_WIDTH-1:0]       m_data;
    logic                          m_sof;
    logic                          m_eol;
    logic                          m_eof;
    modport master (
        output fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof,
        input  fifo_rd_data, fifo_rd_empty, fifo_rd_cnt, m_ready
    );
    modport slave (
        input  fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof,
        output fifo_rd_data, fifo_rd_empty, fifo_rd_cnt, m_ready
    );
endinterface

// File: rtl/fifo_frame_reader_stream_skid_buf.sv
// stream_skid_buf: 2-entry main/skid buffer; outputs come straight from the main register.
module stream_skid_buf #(
    parameter int C_W = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    input  logic [C_W-1:0] i_data,
    input  logic           i_ready,
    output logic           o_valid,
    output logic           o_skid_valid,
    output logic [C_W-1:0] o_data
);
    logic           r_main_valid, r_skid_valid, w_load;
    logic [C_W-1:0] r_main, r_skid;

    // main takes a new word when it is empty or being drained; skid always has priority
    assign w_load       = ~r_main_valid | i_ready;
    assign o_valid      = r_main_valid;
    assign o_skid_valid = r_skid_valid;
    assign o_data       = r_main;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else begin
            if (w_load) begin
                r_main_valid <= r_skid_valid | i_valid;
                r_skid_valid <= r_skid_valid & i_valid;
                if (r_skid_valid | i_valid) r_main <= r_skid_valid ? r_skid : i_data;
            end else if (i_valid) begin
                r_skid_valid <= 1'b1;
            end
            if (i_valid) r_skid <= i_data;
        end
    end
endmodule

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pops a show-ahead FIFO and emits frame-tagged pixels on a valid/ready stream.
// Optional FIFO_FRAME_READER_STARVE_CNT_EN adds starvation and minimum-level monitors.
module fifo_frame_reader
    import fifo_frame_reader_pkg::*;
#(
    parameter int C_DATA_WIDTH       = 8,
    parameter int C_FIFO_DEPTH_WIDTH = 4,
    parameter int C_IMG_WIDTH        = 640,
    parameter int C_IMG_HEIGHT       = 480,
    parameter int C_CNT_WIDTH        = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    fifo_frame_reader_if.master bus,
    output logic                o_frame_done,
    output logic                o_busy
`ifdef FIFO_FRAME_READER_STARVE_CNT_EN
    ,
    output logic [15:0]                   o_starve_cnt,
    output logic [C_FIFO_DEPTH_WIDTH:0]   o_min_level
`endif
);
    localparam int C_PW = C_DATA_WIDTH + TAG_W;

    state_t                 r_state, w_next;
    logic [C_CNT_WIDTH-1:0] r_col, r_row;
    logic                   r_frame_done;
    logic                   w_pop, w_acc, w_skid_valid, w_last_col, w_last_row;
    logic [TAG_W-1:0]       w_tag;
    logic [C_PW-1:0]        w_out;

    assign w_last_col     = r_col == C_CNT_WIDTH'(C_IMG_WIDTH - 1);
    assign w_last_row     = r_row == C_CNT_WIDTH'(C_IMG_HEIGHT - 1);
    assign w_tag[TAG_SOF] = (r_col == '0) & (r_row == '0);
    assign w_tag[TAG_EOL] = w_last_col;
    assign w_tag[TAG_EOF] = w_last_col & w_last_row;

    // popping stops once the skid entry is occupied, so the buffer never overflows
    assign w_pop          = ~rst & (r_state == S_RUN) & ~bus.fifo_rd_empty & ~w_skid_valid;
    assign w_acc          = bus.m_valid & bus.m_ready;
    assign bus.fifo_rd_en = w_pop;
    assign bus.m_data     = w_out[C_PW-1:TAG_W];
    assign bus.m_sof      = w_out[TAG_SOF];
    assign bus.m_eol      = w_out[TAG_EOL];
    assign bus.m_eof      = w_out[TAG_EOF];
    assign o_busy         = r_state != S_IDLE;
    assign o_frame_done   = r_frame_done;

    stream_skid_buf #(.C_W(C_PW)) u_buf (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (w_pop),
        .i_data       ({bus.fifo_rd_data, w_tag}),
        .i_ready      (bus.m_ready),
        .o_valid      (bus.m_valid),
        .o_skid_valid (w_skid_valid),
        .o_data       (w_out)
    );

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && i_enable) w_next = S_RUN;
        if (r_state == S_RUN && w_pop && w_tag[TAG_EOF]) w_next = S_LAST;
        if (r_state == S_LAST && w_acc && bus.m_eof) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_frame_done <= (r_state == S_LAST) & w_acc & bus.m_eof;
            if (w_pop) begin
                r_col <= w_last_col ? '0 : r_col + C_CNT_WIDTH'(1);
                r_row <= w_last_col ? (w_last_row ? '0 : r_row + C_CNT_WIDTH'(1)) : r_row;
            end
        end
    end

`ifdef FIFO_FRAME_READER_STARVE_CNT_EN
    logic [15:0]                 r_starve_cnt;
    logic [C_FIFO_DEPTH_WIDTH:0] r_min_level;

    assign o_starve_cnt = r_starve_cnt;
    assign o_min_level  = r_min_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_min_level  <= '0;
        end else begin
            if (w_pop && w_tag[TAG_SOF])
                r_starve_cnt <= '0;
            else if (r_state == S_RUN && bus.m_ready && !bus.m_valid && bus.fifo_rd_empty && r_starve_cnt != 16'hFFFF)
                r_starve_cnt <= r_starve_cnt + 16'd1;
            if (w_pop && w_tag[TAG_SOF])
                r_min_level <= bus.fifo_rd_cnt;
            else if (r_state == S_RUN && bus.fifo_rd_cnt < r_min_level)
                r_min_level <= bus.fifo_rd_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: the bench plays the FIFO (a queue) and scores the stream against
// frame positions derived from the accept ordinal; also covers the optional monitors.
module tb_fifo_frame_reader;
    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_enable = 1'b0;
    logic o_frame_done, o_busy;
`ifdef FIFO_FRAME_READER_STARVE_CNT_EN
    logic [15:0] o_starve_cnt;
    logic [4:0]  o_min_level;
    int          starve_exp = 0;
    int          min_exp = 0;
`endif

    fifo_frame_reader_if #(.C_DATA_WIDTH(8), .C_FIFO_DEPTH_WIDTH(4)) bus ();

    fifo_frame_reader #(
        .C_DATA_WIDTH(8), .C_FIFO_DEPTH_WIDTH(4), .C_IMG_WIDTH(W), .C_IMG_HEIGHT(H), .C_CNT_WIDTH(12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .bus          (bus),
        .o_frame_done (o_frame_done),
        .o_busy       (o_busy)
`ifdef FIFO_FRAME_READER_STARVE_CNT_EN
        ,
        .o_starve_cnt (o_starve_cnt),
        .o_min_level  (o_min_level)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int  held = 0, n_acc = 0, frame_pops = 0;
    bit  frame_open = 0, done_exp = 0;
    int  n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_rd_empty = fifo_q.size() == 0;
        bus.fifo_rd_data  = fifo_q.size() > 0 ? fifo_q[0] : 8'h00;
        bus.fifo_rd_cnt   = 5'(fifo_q.size());
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_fifo();
        @(negedge clk);
        check("rd_en_in_reset", 32'(bus.fifo_rd_en), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        held = 0; n_acc = 0; frame_pops = 0; frame_open = 0; done_exp = 0;
`ifdef FIFO_FRAME_READER_STARVE_CNT_EN
        starve_exp = 0; min_exp = 0;
`endif
        drive_fifo();
        check("reset_m_valid", 32'(bus.m_valid), 0);
        check("reset_m_data", 32'(bus.m_data), 0);
        check("reset_busy", 32'(o_busy), 0);
        check("reset_frame_done", 32'(o_frame_done), 0);
    endtask

    // one clock: inputs are stable, outputs sampled at negedge, model advanced after posedge
    task automatic cycle();
        bit pop, acc, run, was_open, eof_acc, rdy;
        int sz;
        drive_fifo();
        @(negedge clk);
        pop = bus.fifo_rd_en;
        acc = bus.m_valid & bus.m_ready;
        rdy = bus.m_ready;
        run = frame_open && frame_pops < N;
        sz = fifo_q.size();
        was_open = frame_open;
        check("rd_en", 32'(bus.fifo_rd_en), 32'(run && sz > 0 && held < 2));
        check("m_valid", 32'(bus.m_valid), 32'(held > 0));
        check("busy", 32'(o_busy), 32'(frame_open));
        check("frame_done", 32'(o_frame_done), 32'(done_exp));
`ifdef FIFO_FRAME_READER_STARVE_CNT_EN
        check("starve_cnt", 32'(o_starve_cnt), 32'(starve_exp));
        check("min_level", 32'(o_min_level), 32'(min_exp));
`endif
        if (acc) begin
            check("acc_data", 32'(bus.m_data), exp_q.size() > 0 ? 32'(exp_q[0]) : 32'hxxxxxxxx);
            check("acc_sof", 32'(bus.m_sof), 32'(n_acc % N == 0));
            check("acc_eol", 32'(bus.m_eol), 32'(n_acc % W == W - 1));
            check("acc_eof", 32'(bus.m_eof), 32'(n_acc % N == N - 1));
        end
        @(posedge clk);
        #1;
`ifdef FIFO_FRAME_READER_STARVE_CNT_EN
        if (run && pop && frame_pops == 0) begin
            starve_exp = 0;
            min_exp = sz;
        end else if (run) begin
            if (rdy && held == 0 && sz == 0 && starve_exp < 65535) starve_exp++;
            if (sz < min_exp) min_exp = sz;
        end
`endif
        done_exp = 0;
        if (acc) begin
            eof_acc = n_acc % N == N - 1;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            n_acc++;
            if (held > 0) held--;
            if (eof_acc) begin
                frame_open = 0;
                done_exp = 1;
            end
        end
        if (pop) begin
            if (sz > 0) void'(fifo_q.pop_front());
            held++;
            frame_pops++;
        end
        if (!was_open && i_enable) begin
            frame_open = 1;
            frame_pops = 0;
        end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        drive_fifo();
        do_reset();

        // full frame at one pixel per cycle
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        i_enable = 1'b1;
        bus.m_ready = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < 8; i++) begin
            check("beat_valid", 32'(bus.m_valid), 1);
            check("beat_data", 32'(bus.m_data), 32'(8'h10 + i));
            cycle();
        end
        check("frame_done_pulse", 32'(o_frame_done), 1);

        // backpressure mid-line
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        repeat (3) cycle();
        bus.m_ready = 1'b0;
        repeat (5) cycle();
        check("bp_rd_en_stopped", 32'(bus.fifo_rd_en), 0);
        check("bp_head", 32'(bus.m_data), 32'h21);
        bus.m_ready = 1'b1;
        repeat (12) cycle();
        check("bp_all_accepted", 32'(n_acc), 8);

        // FIFO starvation after three words
        do_reset();
        for (int i = 0; i < 3; i++) push(8'(8'h30 + i));
        repeat (14) cycle();
        check("starve_gap_valid", 32'(bus.m_valid), 0);
        for (int i = 3; i < 8; i++) push(8'(8'h30 + i));
        repeat (10) cycle();
        check("starve_all_accepted", 32'(n_acc), 8);

        // enable dropped mid-frame: frame finishes, then reader idles
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
        cycle();
        i_enable = 1'b0;
        for (int i = 0; i < 20 && !o_frame_done; i++) cycle();
        check("en_frame1_done", 32'(o_frame_done), 1);
        for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
        repeat (8) cycle();
        check("en_idle_rd_en", 32'(bus.fifo_rd_en), 0);
        check("en_idle_busy", 32'(o_busy), 0);
        i_enable = 1'b1;
        cycle();
        cycle();
        check("en_restart_sof", 32'(bus.m_sof), 1);
        check("en_restart_data", 32'(bus.m_data), 32'h60);
        repeat (6) cycle();

        // reset in the middle of a frame
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(8'h70 + i));
        repeat (6) cycle();
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
        cycle();
        cycle();
        check("rst_restart_sof", 32'(bus.m_sof), 1);
        check("rst_restart_data", 32'(bus.m_data), 32'h80);
        repeat (10) cycle();

        // random traffic against the reference model
        do_reset();
        repeat (800) begin
            bus.m_ready = $urandom_range(0, 3) != 0;
            i_enable = $urandom_range(0, 7) != 0;
            if (fifo_q.size() < 16 && $urandom_range(0, 1) == 1) push(8'($urandom));
            cycle();
        end

`ifdef FIFO_FRAME_READER_STARVE_CNT_EN
        do_reset();
        i_enable = 1'b1;
        bus.m_ready = 1'b1;
        cycle();
        repeat (6) cycle();
        check("starve_six", 32'(o_starve_cnt), 6);
        push(8'h90);
        cycle();
        check("starve_cleared", 32'(o_starve_cnt), 0);
        check("min_level_reload", 32'(o_min_level), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
